// File: rtl/wide_lut_mem_pkg.sv
// Shared bus package: bus width constant and the helpers that map a user
// word width onto 16-bit bus chunks and a power-of-two address stride.
package wide_lut_mem_pkg;

    localparam int BUS_W = 16;

    // Number of 16-bit bus chunks needed to carry one user word.
    function automatic int calcChunks(input int width);
        return (width + BUS_W - 1) / BUS_W;
    endfunction

    // Address stride per word: chunk count rounded up to 1, 2 or 4 so the
    // word/chunk split is a plain shift and mask.
    function automatic int calcStride(input int chunks);
        if (chunks <= 1) begin
            return 1;
        end else if (chunks <= 2) begin
            return 2;
        end else begin
            return 4;
        end
    endfunction

endpackage

// File: rtl/wide_lut_mem_if.sv
// Upstream/downstream 16-bit bus bundle. The core sits on the slave side:
// it consumes the *_i group and drives the registered *_o group.
interface wide_lut_mem_if;
    import wide_lut_mem_pkg::*;

    logic [BUS_W-1:0] addr_i;
    logic [BUS_W-1:0] wdata_i;
    logic [BUS_W-1:0] rdata_i;
    logic             rw_i;
    logic             valid_i;

    logic [BUS_W-1:0] addr_o;
    logic [BUS_W-1:0] wdata_o;
    logic [BUS_W-1:0] rdata_o;
    logic             rw_o;
    logic             valid_o;

    modport slave (
        input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
        output addr_o, wdata_o, rdata_o, rw_o, valid_o
    );

    modport master (
        output addr_i, wdata_i, rdata_i, rw_i, valid_i,
        input  addr_o, wdata_o, rdata_o, rw_o, valid_o
    );

endinterface

// File: rtl/wide_lut_mem_decode.sv
// Combinational bus address decode: range check against the owned window
// and split of the offset into word index (shift) and chunk index (mask).
module wide_lut_mem_decode
    import wide_lut_mem_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BASE_ADDR = 0,
    parameter int STRIDE    = 2,
    parameter int AW        = 3
) (
    input  logic [BUS_W-1:0] addr_i,
    output logic             inRange_o,
    output logic [AW-1:0]    word_o,
    output logic [1:0]       chunk_o
);

    localparam int SHIFT = $clog2(STRIDE);
    localparam int SPAN  = DEPTH * STRIDE;

    logic [BUS_W:0] offset;

    // Offset is one bit wider than the bus so addresses below the base wrap
    // to large values and fail the span check as well as the base check.
    always_comb begin
        offset    = {1'b0, addr_i} - (BUS_W + 1)'(BASE_ADDR);
        inRange_o = (addr_i >= BUS_W'(BASE_ADDR)) && (offset < (BUS_W + 1)'(SPAN));
        word_o    = AW'(offset >> SHIFT);
        chunk_o   = 2'(offset & (BUS_W + 1)'(STRIDE - 1));
    end

endmodule

// File: rtl/wide_lut_mem.sv
// Wide lookup memory shared between a 16-bit chunked bus and a full-width
// user port. Bus writes stage lower chunks and commit the whole word on the
// top chunk; bus reads snapshot the word on chunk 0 so later chunks are
// coherent with it.
module wide_lut_mem
    import wide_lut_mem_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 8,
    parameter  int BASE_ADDR = 0,
    parameter  int READ_ONLY = 0,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    wide_lut_mem_if.slave    bus,
    input  logic [AW-1:0]    user_addr,
    input  logic [WIDTH-1:0] user_wdata,
    input  logic             user_we,
    output logic [WIDTH-1:0] user_rdata
);

    localparam int         CHUNKS     = calcChunks(WIDTH);
    localparam int         STRIDE     = calcStride(CHUNKS);
    localparam int         STAGE_W    = (CHUNKS > 1) ? BUS_W * (CHUNKS - 1) : BUS_W;
    localparam logic [2:0] NUM_CHUNKS = 3'(CHUNKS);
    localparam logic [2:0] TOP_CHUNK  = 3'(CHUNKS - 1);

    logic             inRange;
    logic [AW-1:0]    busWord;
    logic [1:0]       busChunk;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [STAGE_W-1:0] wstage_q;
    logic [WIDTH-1:0] rsnap_q;
    logic [AW-1:0]    snapWord_q;
    logic             snapVld_q;

    logic [BUS_W-1:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic             rw_q, valid_q;
    logic [WIDTH-1:0] userRdata_q, userRdata_d;
    logic [WIDTH-1:0] commitWord_d;

    logic             chunkValid, serveRead, busWrite, stageWrite, commitWrite;
    logic             userInRange, userWrite;
    logic [WIDTH-1:0] liveWord;
    logic [63:0]      liveWide, snapWide;

    wide_lut_mem_decode #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .STRIDE    (STRIDE),
        .AW        (AW)
    ) u_decode (
        .addr_i    (bus.addr_i),
        .inRange_o (inRange),
        .word_o    (busWord),
        .chunk_o   (busChunk)
    );

    // Classify the bus transaction, pick the returned chunk (snapshot or
    // live), build the commit word and the user-side read value.
    always_comb begin
        chunkValid  = {1'b0, busChunk} < NUM_CHUNKS;
        serveRead   = bus.valid_i && !bus.rw_i && inRange;
        busWrite    = bus.valid_i && bus.rw_i && inRange && (READ_ONLY == 0) && chunkValid;
        stageWrite  = busWrite && ({1'b0, busChunk} != TOP_CHUNK);
        commitWrite = busWrite && ({1'b0, busChunk} == TOP_CHUNK);

        liveWord = mem_q[busWord];
        liveWide = 64'(liveWord);
        snapWide = 64'(rsnap_q);

        rdata_d = bus.rdata_i;
        if (serveRead) begin
            rdata_d = '0;
            if (chunkValid) begin
                if ((busChunk != 2'd0) && snapVld_q && (snapWord_q == busWord)) begin
                    rdata_d = snapWide[{busChunk, 4'b0000} +: BUS_W];
                end else begin
                    rdata_d = liveWide[{busChunk, 4'b0000} +: BUS_W];
                end
            end
        end

        commitWord_d = (CHUNKS == 1) ? WIDTH'(bus.wdata_i) : WIDTH'({bus.wdata_i, wstage_q});

        userInRange = {1'b0, user_addr} < (AW + 1)'(DEPTH);
        userRdata_d = userInRange ? mem_q[user_addr] : '0;
        userWrite   = user_we && userInRange;
    end

    // Registered bus pass-through, memory updates (bus commit placed last so
    // it wins over a same-word user write), staging and read snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rw_q        <= 1'b0;
            valid_q     <= 1'b0;
            userRdata_q <= '0;
            wstage_q    <= '0;
            rsnap_q     <= '0;
            snapWord_q  <= '0;
            snapVld_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            addr_q      <= bus.addr_i;
            wdata_q     <= bus.wdata_i;
            rdata_q     <= rdata_d;
            rw_q        <= bus.rw_i;
            valid_q     <= bus.valid_i;
            userRdata_q <= userRdata_d;
            if (userWrite) begin
                mem_q[user_addr] <= user_wdata;
            end
            if (commitWrite) begin
                mem_q[busWord] <= commitWord_d;
            end
            if (stageWrite) begin
                wstage_q[{busChunk, 4'b0000} +: BUS_W] <= bus.wdata_i;
            end
            if (serveRead && (busChunk == 2'd0)) begin
                rsnap_q    <= liveWord;
                snapWord_q <= busWord;
                snapVld_q  <= 1'b1;
            end
        end
    end

    assign bus.addr_o  = addr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.rdata_o = rdata_q;
    assign bus.rw_o    = rw_q;
    assign bus.valid_o = valid_q;
    assign user_rdata  = userRdata_q;

endmodule

// File: tb/tb_wide_lut_mem.sv
// Scoreboard bench for wide_lut_mem: three instances (32-bit at base 4,
// 48-bit with a non power-of-two depth, and a read-only 32-bit core).
// Expectations are queued when a cycle is driven and checked one edge later.
module tb_wide_lut_mem;
    import wide_lut_mem_pkg::*;

    localparam int D32 = 0;
    localparam int D48 = 1;
    localparam int DRO = 2;

    localparam int S32_RDATA = 0;
    localparam int S32_USER  = 1;
    localparam int S32_ADDR  = 2;
    localparam int S32_WDATA = 3;
    localparam int S32_RW    = 4;
    localparam int S32_VALID = 5;
    localparam int S48_RDATA = 6;
    localparam int S48_USER  = 7;
    localparam int SRO_RDATA = 8;
    localparam int SRO_USER  = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wide_lut_mem_if bus32();
    wide_lut_mem_if bus48();
    wide_lut_mem_if busRo();

    logic [2:0]  u32Addr;
    logic [31:0] u32Wdata, u32Rdata;
    logic        u32We;
    logic [1:0]  u48Addr;
    logic [47:0] u48Wdata, u48Rdata;
    logic        u48We;
    logic [2:0]  uRoAddr;
    logic [31:0] uRoWdata, uRoRdata;
    logic        uRoWe;

    wide_lut_mem #(.WIDTH(32), .DEPTH(8), .BASE_ADDR(4), .READ_ONLY(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32),
        .user_addr(u32Addr), .user_wdata(u32Wdata), .user_we(u32We), .user_rdata(u32Rdata)
    );

    wide_lut_mem #(.WIDTH(48), .DEPTH(3), .BASE_ADDR(256), .READ_ONLY(0)) dut48 (
        .clk(clk), .rst_n(rst_n), .bus(bus48),
        .user_addr(u48Addr), .user_wdata(u48Wdata), .user_we(u48We), .user_rdata(u48Rdata)
    );

    wide_lut_mem #(.WIDTH(32), .DEPTH(8), .BASE_ADDR(0), .READ_ONLY(1)) dutRo (
        .clk(clk), .rst_n(rst_n), .bus(busRo),
        .user_addr(uRoAddr), .user_wdata(uRoWdata), .user_we(uRoWe), .user_rdata(uRoRdata)
    );

    typedef struct {
        string       tag;
        int          src;
        logic [63:0] expVal;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] getObs(input int src);
        case (src)
            S32_RDATA: return 64'(bus32.rdata_o);
            S32_USER:  return 64'(u32Rdata);
            S32_ADDR:  return 64'(bus32.addr_o);
            S32_WDATA: return 64'(bus32.wdata_o);
            S32_RW:    return 64'(bus32.rw_o);
            S32_VALID: return 64'(bus32.valid_o);
            S48_RDATA: return 64'(bus48.rdata_o);
            S48_USER:  return 64'(u48Rdata);
            SRO_RDATA: return 64'(busRo.rdata_o);
            SRO_USER:  return 64'(uRoRdata);
            default:   return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int src, input logic [63:0] val);
        sbEntry_t e;
        e.tag    = tag;
        e.src    = src;
        e.expVal = val;
        sbQueue.push_back(e);
    endtask

    task automatic idleInputs();
        bus32.valid_i = 1'b0; bus32.rw_i = 1'b0; bus32.addr_i = '0; bus32.wdata_i = '0; bus32.rdata_i = '0;
        bus48.valid_i = 1'b0; bus48.rw_i = 1'b0; bus48.addr_i = '0; bus48.wdata_i = '0; bus48.rdata_i = '0;
        busRo.valid_i = 1'b0; busRo.rw_i = 1'b0; busRo.addr_i = '0; busRo.wdata_i = '0; busRo.rdata_i = '0;
        u32Addr = '0; u32Wdata = '0; u32We = 1'b0;
        u48Addr = '0; u48Wdata = '0; u48We = 1'b0;
        uRoAddr = '0; uRoWdata = '0; uRoWe = 1'b0;
    endtask

    // Drive one cycle on the selected instance; the others stay idle.
    task automatic applyStimulus(input int d, input logic valid, input logic rw,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rin, input logic [5:0] ua,
                                 input logic [63:0] uw, input logic we);
        @(negedge clk);
        idleInputs();
        case (d)
            D32: begin
                bus32.valid_i = valid; bus32.rw_i = rw; bus32.addr_i = addr;
                bus32.wdata_i = wdata; bus32.rdata_i = rin;
                u32Addr = ua[2:0]; u32Wdata = uw[31:0]; u32We = we;
            end
            D48: begin
                bus48.valid_i = valid; bus48.rw_i = rw; bus48.addr_i = addr;
                bus48.wdata_i = wdata; bus48.rdata_i = rin;
                u48Addr = ua[1:0]; u48Wdata = uw[47:0]; u48We = we;
            end
            default: begin
                busRo.valid_i = valid; busRo.rw_i = rw; busRo.addr_i = addr;
                busRo.wdata_i = wdata; busRo.rdata_i = rin;
                uRoAddr = ua[2:0]; uRoWdata = uw[31:0]; uRoWe = we;
            end
        endcase
    endtask

    task automatic drainScoreboard();
        @(posedge clk);
        #1;
        while (sbQueue.size() > 0) begin
            sbEntry_t e;
            e = sbQueue.pop_front();
            checkOutput(e.tag, getObs(e.src), e.expVal);
        end
    endtask

    initial begin
        idleInputs();

        // Reset: outputs stay zero even with live traffic, a commit is ignored.
        applyStimulus(D32, 1, 0, 16'h0004, 16'h5A5A, 16'hABCD, 1, 64'hDEAD_BEEF, 1);
        pushExpect("rst_rdata", S32_RDATA, 0);
        pushExpect("rst_addr",  S32_ADDR,  0);
        pushExpect("rst_wdata", S32_WDATA, 0);
        pushExpect("rst_valid", S32_VALID, 0);
        pushExpect("rst_user",  S32_USER,  0);
        drainScoreboard();
        applyStimulus(D32, 1, 1, 16'h0007, 16'h7E7E, 16'h1111, 1, 64'hFFFF_FFFF, 1);
        pushExpect("rst_rw", S32_RW, 0);
        drainScoreboard();
        rst_n = 1'b1;
        applyStimulus(D32, 0, 0, 0, 0, 0, 1, 0, 0);
        pushExpect("rst_mem", S32_USER, 0);
        drainScoreboard();

        // Two-chunk write: staging only, then atomic commit.
        applyStimulus(D32, 1, 1, 16'h0006, 16'h1111, 16'h3C3C, 1, 0, 0);
        pushExpect("pt_addr",  S32_ADDR,  16'h0006);
        pushExpect("pt_wdata", S32_WDATA, 16'h1111);
        pushExpect("pt_rw",    S32_RW,    1);
        pushExpect("pt_valid", S32_VALID, 1);
        pushExpect("wr_rdata_pass", S32_RDATA, 16'h3C3C);
        pushExpect("stage_no_commit", S32_USER, 0);
        drainScoreboard();
        applyStimulus(D32, 1, 1, 16'h0007, 16'h2222, 0, 1, 0, 0);
        pushExpect("commit_rbw", S32_USER, 0);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 1, 0, 0);
        pushExpect("commit_word1", S32_USER, 32'h2222_1111);
        pushExpect("idle_valid", S32_VALID, 0);
        drainScoreboard();

        // Snapshot coherency across a user write between chunk reads.
        applyStimulus(D32, 1, 1, 16'h0004, 16'h5555, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D32, 1, 1, 16'h0005, 16'hAAAA, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'h0004, 0, 16'h0F0F, 0, 64'h1234_5678, 1);
        pushExpect("snap_c0", S32_RDATA, 16'h5555);
        pushExpect("user_rbw", S32_USER, 32'hAAAA_5555);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'h0005, 0, 16'h0F0F, 0, 0, 0);
        pushExpect("snap_c1", S32_RDATA, 16'hAAAA);
        pushExpect("user_new", S32_USER, 32'h1234_5678);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'h0007, 0, 0, 0, 0, 0);
        pushExpect("live_other_word", S32_RDATA, 16'h2222);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'h0004, 0, 0, 0, 0, 0);
        pushExpect("reread_c0", S32_RDATA, 16'h5678);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'h0005, 0, 0, 0, 0, 0);
        pushExpect("reread_c1", S32_RDATA, 16'h1234);
        drainScoreboard();

        // Window edges: just above, just below, and the last owned address.
        applyStimulus(D32, 1, 0, 16'd20, 0, 16'hBEEF, 0, 0, 0);
        pushExpect("oor_high", S32_RDATA, 16'hBEEF);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'd3, 0, 16'h1357, 0, 0, 0);
        pushExpect("oor_low", S32_RDATA, 16'h1357);
        drainScoreboard();
        applyStimulus(D32, 1, 0, 16'd19, 0, 16'hFFFF, 0, 0, 0);
        pushExpect("last_addr", S32_RDATA, 16'h0000);
        drainScoreboard();

        // Bus commit vs user write: same word, then different words.
        applyStimulus(D32, 1, 1, 16'd10, 16'hBEEF, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D32, 1, 1, 16'd11, 16'h0000, 0, 3, 64'hFFFF_FFFF, 1);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 3, 0, 0);
        pushExpect("bus_wins", S32_USER, 32'h0000_BEEF);
        drainScoreboard();
        applyStimulus(D32, 1, 1, 16'd12, 16'h4444, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D32, 1, 1, 16'd13, 16'h0004, 0, 5, 64'h5555_5555, 1);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 4, 0, 0);
        pushExpect("both_bus", S32_USER, 32'h0004_4444);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 5, 0, 0);
        pushExpect("both_user", S32_USER, 32'h5555_5555);
        drainScoreboard();

        // valid_i low: no write, rdata passes through.
        applyStimulus(D32, 0, 1, 16'd13, 16'hDEAD, 16'h2468, 0, 0, 0);
        pushExpect("novalid_rdata", S32_RDATA, 16'h2468);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 4, 0, 0);
        pushExpect("novalid_mem", S32_USER, 32'h0004_4444);
        drainScoreboard();

        // Reset mid-sequence drops the staged chunk.
        applyStimulus(D32, 1, 1, 16'd14, 16'h7777, 0, 0, 0, 0);
        drainScoreboard();
        rst_n = 1'b0;
        applyStimulus(D32, 1, 0, 16'd4, 0, 16'hABCD, 4, 0, 0);
        pushExpect("rst2_rdata", S32_RDATA, 0);
        pushExpect("rst2_user",  S32_USER,  0);
        pushExpect("rst2_addr",  S32_ADDR,  0);
        pushExpect("rst2_valid", S32_VALID, 0);
        drainScoreboard();
        rst_n = 1'b1;
        applyStimulus(D32, 1, 1, 16'd15, 16'h0001, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 5, 0, 0);
        pushExpect("rst2_commit", S32_USER, 32'h0001_0000);
        drainScoreboard();
        applyStimulus(D32, 0, 0, 0, 0, 0, 4, 0, 0);
        pushExpect("rst2_mem_clear", S32_USER, 0);
        drainScoreboard();

        // 48-bit core: three-chunk commit, padding chunk, range edges.
        applyStimulus(D48, 1, 1, 16'h0104, 16'h1111, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D48, 1, 1, 16'h0105, 16'h2222, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(D48, 1, 1, 16'h0106, 16'h3333, 0, 1, 0, 0);
        pushExpect("w48_pre", S48_USER, 0);
        drainScoreboard();
        applyStimulus(D48, 1, 1, 16'h0107, 16'hFFFF, 0, 1, 0, 0);
        pushExpect("w48_commit", S48_USER, 48'h3333_2222_1111);
        drainScoreboard();
        applyStimulus(D48, 1, 0, 16'h0107, 0, 16'hAAAA, 1, 0, 0);
        pushExpect("w48_pad_read", S48_RDATA, 0);
        pushExpect("w48_pad_write", S48_USER, 48'h3333_2222_1111);
        drainScoreboard();
        applyStimulus(D48, 1, 0, 16'h0104, 0, 0, 2, 64'hFEDC_BA98_7654, 1);
        pushExpect("w48_c0", S48_RDATA, 16'h1111);
        drainScoreboard();
        applyStimulus(D48, 1, 0, 16'h0106, 0, 0, 0, 0, 0);
        pushExpect("w48_c2", S48_RDATA, 16'h3333);
        drainScoreboard();
        applyStimulus(D48, 1, 0, 16'h010A, 0, 0, 0, 0, 0);
        pushExpect("w48_live", S48_RDATA, 16'hFEDC);
        drainScoreboard();
        applyStimulus(D48, 1, 0, 16'h010B, 0, 16'h4321, 0, 0, 0);
        pushExpect("w48_last_pad", S48_RDATA, 0);
        drainScoreboard();
        applyStimulus(D48, 1, 0, 16'h010C, 0, 16'hBEEF, 0, 0, 0);
        pushExpect("w48_oor", S48_RDATA, 16'hBEEF);
        drainScoreboard();
        applyStimulus(D48, 0, 0, 0, 0, 0, 3, 64'h1234_5678_9ABC, 1);
        pushExpect("w48_user_oor_rd", S48_USER, 0);
        drainScoreboard();
        applyStimulus(D48, 0, 0, 0, 0, 0, 2, 0, 0);
        pushExpect("w48_user_w2", S48_USER, 48'hFEDC_BA98_7654);
        drainScoreboard();

        // Read-only core: bus writes dropped, user port still writes.
        applyStimulus(DRO, 1, 1, 16'd4, 16'h1234, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(DRO, 1, 1, 16'd5, 16'h5678, 0, 0, 0, 0);
        drainScoreboard();
        applyStimulus(DRO, 0, 0, 0, 0, 0, 2, 0, 0);
        pushExpect("ro_no_write", SRO_USER, 0);
        drainScoreboard();
        applyStimulus(DRO, 1, 0, 16'd4, 0, 16'h9999, 2, 64'hCAFE, 1);
        pushExpect("ro_pre", SRO_RDATA, 0);
        drainScoreboard();
        applyStimulus(DRO, 1, 0, 16'd4, 0, 16'h9999, 0, 0, 0);
        pushExpect("ro_user_write", SRO_RDATA, 16'hCAFE);
        drainScoreboard();
        applyStimulus(DRO, 1, 0, 16'd5, 0, 16'h9999, 0, 0, 0);
        pushExpect("ro_c1", SRO_RDATA, 16'h0000);
        drainScoreboard();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wide_lut_mem.md
WIDE_LUT_MEM -- requirements
Module: wide_lut_mem

Interface
REQ-001 Parameter WIDTH, default 32, user word width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 8, number of user words, legal range 1..64.
REQ-003 Parameter BASE_ADDR, default 0, first bus address owned by the core.
REQ-004 Parameter READ_ONLY, default 0: when 1, bus writes are ignored and only the user port writes.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 addr_i / wdata_i / rdata_i  in  16 each  upstream bus address, write data, read data.
REQ-008 rw_i / valid_i  in  1 each  upstream bus direction (1 = write), transaction valid.
REQ-009 addr_o / wdata_o / rdata_o  out  16 each  downstream bus, registered.
REQ-010 rw_o / valid_o  out  1 each  downstream bus, registered.
REQ-011 user_addr  in  max(1,clog2(DEPTH))  user-side word index.
REQ-012 user_wdata  in  WIDTH  user-side write data.
REQ-013 user_we  in  1  user-side write enable.
REQ-014 user_rdata  out  WIDTH  user-side read data, registered.

Function
REQ-015 CHUNKS = ceil(WIDTH/16); STRIDE = CHUNKS rounded up to a power of two (1, 2 or 4); the core owns bus addresses BASE_ADDR .. BASE_ADDR+DEPTH*STRIDE-1.
REQ-016 Offset = addr_i-BASE_ADDR; word = offset/STRIDE; chunk = offset mod STRIDE. No divider; use shift and mask only.
REQ-017 All bus outputs update one cycle after their inputs. addr/wdata/rw/valid pass through unchanged. rdata_o = rdata_i unless this core serves a read.
REQ-018 The core serves a read when valid_i=1, rw_i=0 and the address is in range; rdata_o then carries the served chunk. Bits above WIDTH are zero.
REQ-019 Chunk addresses with CHUNKS <= chunk < STRIDE read 0, and writes to them are ignored.
REQ-020 Bus write, chunk < CHUNKS-1: wdata_i is stored in staging register wstage[chunk]; memory is not changed.
REQ-021 Bus write, chunk = CHUNKS-1: mem[word] is written atomically with {wdata_i, wstage[CHUNKS-2..0]}, truncated to WIDTH. When CHUNKS=1, the write goes straight to mem.
REQ-022 Bus read, chunk 0: returns mem[word][15:0]. The same cycle captures mem[word] into rsnap, sets snap_word=word and sets snap_vld=1.
REQ-023 Bus read, chunk c>0: returns rsnap chunk c if snap_vld and snap_word=word; otherwise returns the live chunk c of mem[word].
REQ-024 READ_ONLY=1: all bus writes, including staging writes, are ignored; bus reads are unaffected.
REQ-025 User port: user_rdata <= mem[user_addr] one cycle later, read-before-write.
REQ-026 User write: mem[user_addr] <= user_wdata when user_we=1.
REQ-027 If a user_addr >= DEPTH is written, the write is ignored; if it is read, user_rdata returns 0.
REQ-028 Same-cycle bus commit and user write to the same word: the bus commit wins. Different words: both take effect.
REQ-029 Same-cycle user write and bus chunk-0 read of the same word: rsnap and rdata_o receive the pre-write value.
REQ-030 Out-of-range or valid_i=0 transactions leave mem, wstage and rsnap untouched.

Reset
REQ-031 While rst_n=0 at a clock edge, the following clear to 0: addr_o, wdata_o, rdata_o, rw_o, valid_o, user_rdata, all wstage entries, rsnap, snap_word, snap_vld and all mem words.
REQ-032 Reset mid-sequence discards a partially staged write; a later top-chunk write commits with zero lower chunks.

Structure
REQ-033 CHUNKS/STRIDE derivation functions and the 16-bit bus width constant live in the shared bus package, for reuse by other cores.
REQ-034 One sub-module, wide_lut_mem_decode, SHALL perform range check and word/chunk split combinationally; everything else stays in wide_lut_mem.

Verification
REQ-035 WIDTH=32, BASE_ADDR=4: write 0x1111 to addr 6, then 0x2222 to addr 7 -> user_addr=1 reads 0x22221111 only after the second write.
REQ-036 WIDTH=32: mem[0]=0xAAAA5555, read addr 0, user writes 0x12345678 to word 0, read addr 1 -> rdata_o 0x5555 then 0xAAAA (snapshot).
REQ-037 WIDTH=48 (STRIDE 4): read chunk 3 -> 0; write chunk 3 -> no change; valid read at addr beyond range with rdata_i=0xBEEF -> rdata_o=0xBEEF.
REQ-038 READ_ONLY=1: bus writes to chunks 0 and 1 of word 2 -> mem unchanged; user writes 0xCAFE to word 2 -> bus read of chunk 0 returns 0xCAFE.
REQ-039 Simultaneous bus commit 0x0000BEEF and user write 0xFFFFFFFF to word 3 -> word 3 = 0x0000BEEF.
REQ-040 Stage chunk 0 = 0x7777, pulse rst_n low one cycle, write chunk 1 = 0x0001 -> word = 0x00010000; all outputs 0 during reset.
